// File: rtl/aes_ctr_keystream_combiner.sv
// AES-CTR keystream combiner: buffers keystream blocks and XORs them onto plaintext beats.
// Define AES_CTR_COMB_OUTREG_EN for a registered 2-entry skid output stage (default: combinational output).
module aes_ctr_keystream_combiner #(
   parameter int BLOCK_WIDTH      = 128,
   parameter int KS_FIFO_DEPTH    = 4,
   parameter int IV_COUNTER_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic [BLOCK_WIDTH-1:0]              ks_tdata,
   input  logic                                ks_tvalid,
   output logic                                ks_tready,
   input  logic [BLOCK_WIDTH-1:0]              s_axis_tdata,
   input  logic [BLOCK_WIDTH/8-1:0]            s_axis_tkeep,
   input  logic                                s_axis_tvalid,
   input  logic                                s_axis_tlast,
   output logic                                s_axis_tready,
   output logic [BLOCK_WIDTH-1:0]              m_axis_tdata,
   output logic [BLOCK_WIDTH/8-1:0]            m_axis_tkeep,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   output logic [$clog2(KS_FIFO_DEPTH+1)-1:0]  ks_level,
   output logic [IV_COUNTER_WIDTH-1:0]         block_count,
   output logic                                ctr_exhausted
);
   localparam int KW = BLOCK_WIDTH / 8;
   localparam int LW = $clog2(KS_FIFO_DEPTH + 1);
   localparam int AW = $clog2(KS_FIFO_DEPTH);

   logic [BLOCK_WIDTH-1:0]      fifoMem [KS_FIFO_DEPTH];
   logic [AW-1:0]               wrPtr_q, rdPtr_q;
   logic [LW-1:0]               level_q, level_d;
   logic [IV_COUNTER_WIDTH-1:0] count_q, count_d;
   logic                        exhausted_q, exhausted_d;
   logic                        push, pop, inputOk, outCanAccept;
   logic [BLOCK_WIDTH-1:0]      keepMask, cipherData;

   // Every ready/valid is gated by rst_n so outputs fall to idle without waiting for a clock edge.
   assign ks_tready     = rst_n && (level_q < LW'(KS_FIFO_DEPTH)) && !flush;
   assign push          = ks_tvalid && ks_tready;
   assign inputOk       = rst_n && (level_q != '0) && !flush && !exhausted_q;
   assign s_axis_tready = inputOk && outCanAccept;
   assign pop           = s_axis_tvalid && s_axis_tready;

   always_comb begin
      keepMask = '0;
      for (int b = 0; b < KW; b++) begin
         keepMask[b*8 +: 8] = {8{s_axis_tkeep[b]}};
      end
   end

   assign cipherData = (s_axis_tdata ^ fifoMem[rdPtr_q]) & keepMask;

   always_comb begin
      level_d     = level_q;
      count_d     = count_q;
      exhausted_d = exhausted_q;
      if (flush) begin
         level_d     = '0;
         count_d     = '0;
         exhausted_d = 1'b0;
      end else begin
         level_d = level_q + LW'(push) - LW'(pop);
         if (pop) begin
            count_d = count_q + IV_COUNTER_WIDTH'(1);
            if (&count_q) exhausted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         count_q     <= '0;
         exhausted_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         count_q     <= count_d;
         exhausted_q <= exhausted_d;
         if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
         end else begin
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr_q] <= ks_tdata;
   end

   assign ks_level      = level_q;
   assign block_count   = count_q;
   assign ctr_exhausted = exhausted_q;

`ifdef AES_CTR_COMB_OUTREG_EN
   logic                   outValid_q, skidValid_q, outLast_q, skidLast_q;
   logic [BLOCK_WIDTH-1:0] outData_q, skidData_q;
   logic [KW-1:0]          outKeep_q, skidKeep_q;

   // Readiness comes only from the skid slot, so s_axis_tready never sees m_axis_tready.
   assign outCanAccept = !skidValid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outKeep_q   <= '0;
         outLast_q   <= 1'b0;
         skidValid_q <= 1'b0;
         skidData_q  <= '0;
         skidKeep_q  <= '0;
         skidLast_q  <= 1'b0;
      end else if (flush) begin
         outValid_q  <= 1'b0;
         skidValid_q <= 1'b0;
      end else if (!outValid_q || m_axis_tready) begin
         if (skidValid_q) begin
            outValid_q  <= 1'b1;
            outData_q   <= skidData_q;
            outKeep_q   <= skidKeep_q;
            outLast_q   <= skidLast_q;
            skidValid_q <= 1'b0;
         end else begin
            outValid_q <= pop;
            if (pop) begin
               outData_q <= cipherData;
               outKeep_q <= s_axis_tkeep;
               outLast_q <= s_axis_tlast;
            end
         end
      end else if (pop) begin
         skidValid_q <= 1'b1;
         skidData_q  <= cipherData;
         skidKeep_q  <= s_axis_tkeep;
         skidLast_q  <= s_axis_tlast;
      end
   end

   assign m_axis_tvalid = outValid_q;
   assign m_axis_tdata  = outData_q;
   assign m_axis_tkeep  = outKeep_q;
   assign m_axis_tlast  = outLast_q;
`else
   assign outCanAccept  = m_axis_tready;
   assign m_axis_tvalid = s_axis_tvalid && inputOk;
   assign m_axis_tdata  = rst_n ? cipherData : '0;
   assign m_axis_tkeep  = rst_n ? s_axis_tkeep : '0;
   assign m_axis_tlast  = rst_n && s_axis_tlast;
`endif

endmodule

// File: tb/tb_aes_ctr_keystream_combiner.sv
// Testbench for aes_ctr_keystream_combiner: directed scenarios plus randomized traffic
// compared against a queue-based reference model; works with or without AES_CTR_COMB_OUTREG_EN.
`timescale 1ns/1ps
module tb_aes_ctr_keystream_combiner;
   localparam int BW      = 128;
   localparam int KW      = BW / 8;
   localparam int DEPTH   = 4;
   localparam int CW      = 4;
   localparam int LW      = $clog2(DEPTH + 1);
   localparam int CTR_MOD = 1 << CW;

   typedef struct packed {
      logic [BW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n, flush, ksValid, sValid, sLast, mReady;
   logic [BW-1:0] ksData, sData;
   logic [KW-1:0] sKeep;
   logic          ks_tready, s_axis_tready, m_axis_tvalid, m_axis_tlast, ctr_exhausted;
   logic [BW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [LW-1:0] ks_level;
   logic [CW-1:0] block_count;

   // Reference model state: keystream queue, pending output beats, counter and sticky flag.
   logic [BW-1:0] ksQ[$];
   beat_t         outQ[$];
   int            modelCount = 0;
   bit            modelExh = 1'b0;

   int    assertCount = 0;
   int    failCount = 0;
   int    dutOutCount = 0;
   beat_t lastOut = '0;

   aes_ctr_keystream_combiner #(
      .BLOCK_WIDTH(BW), .KS_FIFO_DEPTH(DEPTH), .IV_COUNTER_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ks_tdata(ksData), .ks_tvalid(ksValid), .ks_tready(ks_tready),
      .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tvalid(sValid),
      .s_axis_tlast(sLast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(mReady),
      .ks_level(ks_level), .block_count(block_count), .ctr_exhausted(ctr_exhausted)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] cipherOf(input logic [BW-1:0] pt, input logic [BW-1:0] ks,
                                              input logic [KW-1:0] keep);
      logic [BW-1:0] r;
      r = pt ^ ks;
      for (int b = 0; b < KW; b++) if (!keep[b]) r[b*8 +: 8] = 8'h00;
      return r;
   endfunction

   // The model predicts, at each falling edge, what the next rising edge will do.
   always @(negedge clk) begin
      logic  expKsReady, expSReady, expMValid, sFire, ksFire, mFire;
      beat_t expOut, nb;
      if (!rst_n) begin
         ksQ.delete();
         outQ.delete();
         modelCount = 0;
         modelExh   = 1'b0;
      end else begin
         expKsReady = (ksQ.size() < DEPTH) && !flush;
         expOut     = '0;
`ifdef AES_CTR_COMB_OUTREG_EN
         expSReady = (ksQ.size() > 0) && !flush && !modelExh && (outQ.size() < 2);
         expMValid = (outQ.size() > 0);
         if (expMValid) expOut = outQ[0];
`else
         expSReady = (ksQ.size() > 0) && !flush && !modelExh && mReady;
         expMValid = sValid && (ksQ.size() > 0) && !flush && !modelExh;
         if (ksQ.size() > 0) begin
            expOut.data = cipherOf(sData, ksQ[0], sKeep);
            expOut.keep = sKeep;
            expOut.last = sLast;
         end
`endif
         assertCount++;
         if (ks_tready !== expKsReady) begin
            failCount++;
            $display("[TB] FAIL mon_ks_tready t=%0t: got %b expected %b", $time, ks_tready, expKsReady);
         end
         assertCount++;
         if (s_axis_tready !== expSReady) begin
            failCount++;
            $display("[TB] FAIL mon_s_tready t=%0t: got %b expected %b", $time, s_axis_tready, expSReady);
         end
         assertCount++;
         if (m_axis_tvalid !== expMValid) begin
            failCount++;
            $display("[TB] FAIL mon_m_tvalid t=%0t: got %b expected %b", $time, m_axis_tvalid, expMValid);
         end
         assertCount++;
         if (ks_level !== LW'(ksQ.size())) begin
            failCount++;
            $display("[TB] FAIL mon_ks_level t=%0t: got %0d expected %0d", $time, ks_level, ksQ.size());
         end
         assertCount++;
         if (block_count !== CW'(modelCount) || ctr_exhausted !== modelExh) begin
            failCount++;
            $display("[TB] FAIL mon_counter t=%0t: got count=%0d exh=%b expected count=%0d exh=%b",
                     $time, block_count, ctr_exhausted, modelCount, modelExh);
         end
         if (expMValid) begin
            assertCount++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== expOut) begin
               failCount++;
               $display("[TB] FAIL mon_out_beat t=%0t: got %h/%h/%b expected %h/%h/%b", $time,
                        m_axis_tdata, m_axis_tkeep, m_axis_tlast, expOut.data, expOut.keep, expOut.last);
            end
         end
         if (m_axis_tvalid && mReady && !flush) begin
            dutOutCount++;
            lastOut = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
         end
         sFire  = sValid && expSReady;
         ksFire = ksValid && expKsReady;
         mFire  = expMValid && mReady && !flush;
         if (flush) begin
            ksQ.delete();
            outQ.delete();
            modelCount = 0;
            modelExh   = 1'b0;
         end else begin
`ifdef AES_CTR_COMB_OUTREG_EN
            if (mFire) void'(outQ.pop_front());
            if (sFire) begin
               nb.data = cipherOf(sData, ksQ[0], sKeep);
               nb.keep = sKeep;
               nb.last = sLast;
               outQ.push_back(nb);
            end
`else
            if (mFire) nb = expOut;
`endif
            if (sFire) begin
               void'(ksQ.pop_front());
               if (modelCount == CTR_MOD - 1) begin
                  modelCount = 0;
                  modelExh   = 1'b1;
               end else begin
                  modelCount++;
               end
            end
            if (ksFire) ksQ.push_back(ksData);
         end
      end
   end

   // Stimulus helpers: all of them start and end at one time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic flushPulse();
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
   endtask

   function automatic logic [BW-1:0] randBlock();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic pushKs(input logic [BW-1:0] d);
      bit done = 1'b0;
      int waited = 0;
      ksValid = 1'b1;
      ksData  = d;
      while (!done) begin
         @(negedge clk);
         if (ks_tready) done = 1'b1;
         idle(1);
         waited++;
         if (!done && waited > 300) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ks_push_timeout: got no ks_tready expected it within 300 cycles");
            done = 1'b1;
         end
      end
      ksValid = 1'b0;
   endtask

   task automatic sendBeat(input logic [BW-1:0] d, input logic [KW-1:0] k, input logic l);
      bit done = 1'b0;
      int waited = 0;
      sValid = 1'b1;
      sData  = d;
      sKeep  = k;
      sLast  = l;
      while (!done) begin
         @(negedge clk);
         if (s_axis_tready) done = 1'b1;
         idle(1);
         waited++;
         if (!done && waited > 300) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL s_send_timeout: got no s_axis_tready expected it within 300 cycles");
            done = 1'b1;
         end
      end
      sValid = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      assertCount++;
      if ({ks_tready, s_axis_tready, m_axis_tvalid, m_axis_tlast, ctr_exhausted} !== 5'b0 ||
          m_axis_tdata !== '0 || m_axis_tkeep !== '0 || ks_level !== '0 || block_count !== '0) begin
         failCount++;
         $display("[TB] FAIL %s: got ksr=%b sr=%b mv=%b ml=%b exh=%b data=%h keep=%h lvl=%0d cnt=%0d expected all zero",
                  tag, ks_tready, s_axis_tready, m_axis_tvalid, m_axis_tlast, ctr_exhausted,
                  m_axis_tdata, m_axis_tkeep, ks_level, block_count);
      end
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      ksValid = 1'b1; ksData = randBlock();
      sValid = 1'b1; sData = randBlock(); sKeep = '1; sLast = 1'b1; mReady = 1'b1;
      #12;
      checkResetValues("reset_outputs");
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      sValid = 1'b0;
      #1;
      assertCount++;
      if (ks_tready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_ks_ready: got %b expected 1", ks_tready);
      end
      @(posedge clk);
      #1;
      ksValid = 1'b0;
      assertCount++;
      if (ks_level !== LW'(1)) begin
         failCount++;
         $display("[TB] FAIL reset_first_push: got %0d expected 1", ks_level);
      end
      flushPulse();
   endtask

   task automatic test_basic();
      int base;
      $display("[TB] test_basic");
      mReady = 1'b1;
      repeat (4) pushKs('1);
      assertCount++;
      if (ks_level !== LW'(4)) begin
         failCount++;
         $display("[TB] FAIL basic_fill: got %0d expected 4", ks_level);
      end
      base = dutOutCount;
      for (int i = 0; i < 4; i++) sendBeat(BW'(1), '1, i == 3);
      idle(3);
      assertCount++;
      if (dutOutCount - base !== 4 || lastOut.data !== {{(BW-8){1'b1}}, 8'hFE} || lastOut.last !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL basic_output: got beats=%0d data=%h last=%b expected 4 ff..fe 1",
                  dutOutCount - base, lastOut.data, lastOut.last);
      end
      assertCount++;
      if (block_count !== CW'(4) || ks_level !== '0) begin
         failCount++;
         $display("[TB] FAIL basic_state: got count=%0d level=%0d expected 4 0", block_count, ks_level);
      end
   endtask

   task automatic test_fifo_full();
      $display("[TB] test_fifo_full");
      flushPulse();
      mReady = 1'b1;
      repeat (4) pushKs(randBlock());
      ksValid = 1'b1;
      ksData  = randBlock();
      @(negedge clk);
      assertCount++;
      if (ks_tready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL full_ready: got %b expected 0", ks_tready);
      end
      idle(1);
      assertCount++;
      if (ks_level !== LW'(4)) begin
         failCount++;
         $display("[TB] FAIL full_level: got %0d expected 4", ks_level);
      end
      sValid = 1'b1; sData = randBlock(); sKeep = '1; sLast = 1'b0;
      @(negedge clk);
      assertCount++;
      if (ks_tready !== 1'b0 || s_axis_tready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL full_pop_cycle: got ksr=%b sr=%b expected 0 1", ks_tready, s_axis_tready);
      end
      idle(1);
      sValid = 1'b0;
      assertCount++;
      if (ks_level !== LW'(3)) begin
         failCount++;
         $display("[TB] FAIL full_after_pop: got %0d expected 3", ks_level);
      end
      idle(1);
      ksValid = 1'b0;
      assertCount++;
      if (ks_level !== LW'(4)) begin
         failCount++;
         $display("[TB] FAIL full_held_push: got %0d expected 4", ks_level);
      end
      idle(3);
   endtask

   task automatic test_tkeep_tlast();
      logic [BW-1:0] k0, pt;
      $display("[TB] test_tkeep_tlast");
      flushPulse();
      mReady = 1'b1;
      k0 = randBlock();
      pt = randBlock();
      pushKs(k0);
      repeat (2) pushKs(randBlock());
      sendBeat(pt, KW'(16'h00FF), 1'b1);
      idle(3);
      assertCount++;
      if (lastOut.data[BW-1:64] !== '0 || lastOut.data[63:0] !== (pt[63:0] ^ k0[63:0])) begin
         failCount++;
         $display("[TB] FAIL keep_data: got %h expected upper zero, lower %h", lastOut.data, pt[63:0] ^ k0[63:0]);
      end
      assertCount++;
      if (lastOut.keep !== KW'(16'h00FF) || lastOut.last !== 1'b1 || ks_level !== LW'(2)) begin
         failCount++;
         $display("[TB] FAIL keep_side: got keep=%h last=%b level=%0d expected 00ff 1 2",
                  lastOut.keep, lastOut.last, ks_level);
      end
      sendBeat(randBlock(), '1, 1'b0);
      idle(3);
      assertCount++;
      if (ks_level !== LW'(1) || block_count !== CW'(2)) begin
         failCount++;
         $display("[TB] FAIL keep_next_packet: got level=%0d count=%0d expected 1 2", ks_level, block_count);
      end
   endtask

   task automatic test_ctr_wrap();
      int base;
      $display("[TB] test_ctr_wrap");
      flushPulse();
      mReady = 1'b1;
      base = dutOutCount;
      fork
         for (int i = 0; i < CTR_MOD; i++) pushKs(randBlock());
         for (int j = 0; j < CTR_MOD; j++) sendBeat(randBlock(), '1, (j % 4) == 3);
      join
      idle(3);
      assertCount++;
      if (dutOutCount - base !== CTR_MOD || block_count !== '0 || ctr_exhausted !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL wrap_state: got beats=%0d count=%0d exh=%b expected %0d 0 1",
                  dutOutCount - base, block_count, ctr_exhausted, CTR_MOD);
      end
      pushKs(randBlock());
      sValid = 1'b1; sData = randBlock(); sKeep = '1; sLast = 1'b0;
      @(negedge clk);
      assertCount++;
      if (s_axis_tready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL wrap_stall: got %b expected 0", s_axis_tready);
      end
      idle(1);
      sValid = 1'b0;
      assertCount++;
      if (ks_level !== LW'(1)) begin
         failCount++;
         $display("[TB] FAIL wrap_no_pop: got %0d expected 1", ks_level);
      end
      flushPulse();
      assertCount++;
      if (ctr_exhausted !== 1'b0 || block_count !== '0) begin
         failCount++;
         $display("[TB] FAIL wrap_flush_clear: got exh=%b count=%0d expected 0 0", ctr_exhausted, block_count);
      end
   endtask

   task automatic test_flush();
      $display("[TB] test_flush");
      flushPulse();
      mReady = 1'b0;
`ifdef AES_CTR_COMB_OUTREG_EN
      repeat (4) pushKs(randBlock());
      sendBeat(randBlock(), '1, 1'b0);
`else
      repeat (3) pushKs(randBlock());
      sValid = 1'b1; sData = randBlock(); sKeep = '1; sLast = 1'b0;
`endif
      @(negedge clk);
      assertCount++;
      if (ks_level !== LW'(3) || m_axis_tvalid !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL flush_setup: got level=%0d mvalid=%b expected 3 1", ks_level, m_axis_tvalid);
      end
      idle(1);
      flush = 1'b1;
      idle(1);
      flush  = 1'b0;
      sValid = 1'b0;
      assertCount++;
      if (ks_level !== '0 || m_axis_tvalid !== 1'b0 || block_count !== '0 || ctr_exhausted !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL flush_result: got level=%0d mvalid=%b count=%0d exh=%b expected 0 0 0 0",
                  ks_level, m_axis_tvalid, block_count, ctr_exhausted);
      end
      mReady = 1'b1;
   endtask

   task automatic test_random();
      $display("[TB] test_random");
      for (int r = 0; r < 4; r++) begin
         int n, base;
         flushPulse();
         n    = $urandom_range(8, 15);
         base = dutOutCount;
         fork
            for (int i = 0; i < n; i++) begin
               idle($urandom_range(0, 2));
               pushKs(randBlock());
            end
            for (int j = 0; j < n; j++) begin
               idle($urandom_range(0, 2));
               sendBeat(randBlock(), KW'($urandom()), 1'($urandom_range(0, 1)));
            end
            begin
               int cyc = 0;
               while (dutOutCount - base < n && cyc < 1000) begin
                  mReady = 1'($urandom_range(0, 1));
                  idle(1);
                  cyc++;
               end
            end
         join
         mReady = 1'b1;
         idle(3);
         assertCount++;
         if (dutOutCount - base !== n || block_count !== CW'(n) || ks_level !== '0) begin
            failCount++;
            $display("[TB] FAIL random_round%0d: got beats=%0d count=%0d level=%0d expected %0d %0d 0",
                     r, dutOutCount - base, block_count, ks_level, n, n);
         end
      end
   endtask

   task automatic test_reset_midpacket();
      $display("[TB] test_reset_midpacket");
      flushPulse();
      mReady = 1'b0;
      repeat (3) pushKs(randBlock());
      sValid = 1'b1; sData = randBlock(); sKeep = '1; sLast = 1'b0;
      ksValid = 1'b1; ksData = randBlock();
      idle(1);
      assertCount++;
      if (m_axis_tvalid !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL midpkt_setup: got mvalid=%b expected 1", m_axis_tvalid);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("midpkt_async_reset");
      ksValid = 1'b0;
      sValid  = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(1);
      assertCount++;
      if (ks_level !== '0 || block_count !== '0 || m_axis_tvalid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midpkt_after_release: got level=%0d count=%0d mvalid=%b expected 0 0 0",
                  ks_level, block_count, m_axis_tvalid);
      end
      mReady = 1'b1;
      idle(2);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; ksValid = 1'b0; sValid = 1'b0; sLast = 1'b0; mReady = 1'b0;
      ksData = '0; sData = '0; sKeep = '0;
      test_reset();
      test_basic();
      test_fifo_full();
      test_tkeep_tlast();
      test_ctr_wrap();
      test_flush();
      test_random();
      test_reset_midpacket();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 400000ns");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
